// File: rtl/tff_counter_pkg.sv
// Shared types and next-state helper for the T-flop modulo counter.
// The helper works on 32-bit values; callers truncate to their own WIDTH.
package tff_counter_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } op_t;

  function automatic logic [31:0] next_count(
    input int unsigned modulus,
    input logic [31:0] cur,
    input op_t         op,
    input logic [31:0] load_val
  );
    logic [31:0] last;
    last = modulus - 32'd1;
    case (op)
      OP_CLEAR: next_count = '0;
      // Out-of-range loads clamp so the count never leaves 0..MODULUS-1.
      OP_LOAD:  next_count = (load_val < modulus) ? load_val : last;
      OP_UP:    next_count = (cur == last) ? '0 : cur + 32'd1;
      OP_DOWN:  next_count = (cur == '0) ? last : cur - 32'd1;
      default:  next_count = cur;
    endcase
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop bit cell with asynchronous active-low reset to Q=0.
module tff_cell (
  input  logic CLK,
  input  logic RST_N,
  input  logic T,
  output logic Q,
  output logic QBAR
);

  logic q_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)  q_q <= 1'b0;
    else if (T)  q_q <= ~q_q;
  end

  assign Q    = q_q;
  assign QBAR = ~q_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter whose state lives only in T cells, plus a
// wrap-toggled divider output and a combinational terminal-count strobe.
module tff_mod_counter
  import tff_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             UP,
  input  logic             SCLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             DIV_OUT,
  output logic             DIV_OUTBAR
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("tff_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  op_t              op;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] qbar_unused;

  always_comb begin
    op = OP_HOLD;
    if (SCLR)      op = OP_CLEAR;
    else if (LOAD) op = OP_LOAD;
    else if (EN)   op = UP ? OP_UP : OP_DOWN;
  end

  assign nxt   = WIDTH'(next_count(MODULUS, 32'(COUNT), op, 32'(LOAD_VAL)));
  // Each cell flips exactly the bits that differ; hold yields all-zero T.
  assign t_vec = COUNT ^ nxt;

  assign TC = EN & ~SCLR & ~LOAD &
              (UP ? (COUNT == WIDTH'(MODULUS - 1)) : (COUNT == '0));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_cell (
      .CLK  (CLK),
      .RST_N(RST_N),
      .T    (t_vec[i]),
      .Q    (COUNT[i]),
      .QBAR (qbar_unused[i])
    );
  end

  tff_cell u_div (
    .CLK  (CLK),
    .RST_N(RST_N),
    .T    (TC),
    .Q    (DIV_OUT),
    .QBAR (DIV_OUTBAR)
  );

endmodule

// File: tb/tb_tff_mod_counter.sv
// Bench for tff_mod_counter: directed vector table, corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_tff_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         EN = 1'b0, UP = 1'b0, SCLR = 1'b0, LOAD = 1'b0;
  logic [W-1:0] LOAD_VAL = '0;
  logic [W-1:0] COUNT;
  logic         TC, DIV_OUT, DIV_OUTBAR;

  tff_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .SCLR(SCLR), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .COUNT(COUNT), .TC(TC), .DIV_OUT(DIV_OUT),
    .DIV_OUTBAR(DIV_OUTBAR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  int mc = 0;   // model count
  int md = 0;   // model divider level

  typedef struct {
    logic en, up, sclr, load;
    int   lv;
    int   cnt;   // expected COUNT after the edge
    logic tc;    // expected TC before the edge
    logic div;   // expected DIV_OUT after the edge
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic void add(input logic en, up, sclr, load, input int lv,
                              input int cnt, input logic tc, input logic div);
    vec_t v;
    v.en = en; v.up = up; v.sclr = sclr; v.load = load; v.lv = lv;
    v.cnt = cnt; v.tc = tc; v.div = div;
    tbl.push_back(v);
  endfunction

  // Called just after a falling edge: drive, check TC, clock, check state.
  task automatic cyc(input logic en, up, sclr, load, input int lv,
                     input string nm, output logic tc_seen);
    int mtc;
    EN = en; UP = up; SCLR = sclr; LOAD = load; LOAD_VAL = W'(lv);
    #1;
    mtc = (en && !sclr && !load && (up ? (mc == M - 1) : (mc == 0))) ? 1 : 0;
    tc_seen = TC;
    chk({nm, " tc"}, int'(TC), mtc);
    @(posedge CLK);
    if (sclr)      mc = 0;
    else if (load) mc = (lv < M) ? lv : M - 1;
    else if (en) begin
      if (mtc == 1) md = 1 - md;
      mc = up ? (mc + 1) % M : (mc + M - 1) % M;
    end
    #1;
    chk({nm, " count"}, int'(COUNT), mc);
    chk({nm, " div"}, int'(DIV_OUT), md);
    chk({nm, " divbar"}, int'(DIV_OUTBAR), 1 - md);
    @(negedge CLK);
  endtask

  // Asserts reset between edges and checks the outputs clear immediately.
  task automatic async_reset(input string nm);
    #2;
    RST_N = 1'b0;
    mc = 0; md = 0;
    #1;
    chk({nm, " rst count"}, int'(COUNT), 0);
    chk({nm, " rst div"}, int'(DIV_OUT), 0);
    chk({nm, " rst divbar"}, int'(DIV_OUTBAR), 1);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    logic tc_s;
    int   toggles;
    logic prev;

    // Directed table from a fresh reset.
    for (int i = 1; i <= 12; i++)
      add(1, 1, 0, 0, 0, i % M, (i == 10), (i >= 10));
    add(0, 0, 0, 1, 3, 3, 0, 1);
    add(1, 0, 0, 0, 0, 2, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 9, 1, 0);
    add(1, 0, 0, 0, 0, 8, 0, 0);
    add(0, 0, 0, 1, 13, 9, 0, 0);   // clamp
    add(1, 1, 1, 1, 5, 0, 0, 0);    // clear beats load and count
    add(0, 0, 0, 1, 5, 5, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 5, 0, 0);
    add(1, 0, 0, 0, 0, 4, 0, 0);
    add(1, 1, 0, 0, 0, 5, 0, 0);

    @(negedge CLK);
    #1;
    chk("reset count", int'(COUNT), 0);
    chk("reset div", int'(DIV_OUT), 0);
    chk("reset divbar", int'(DIV_OUTBAR), 1);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].up, tbl[i].sclr, tbl[i].load, tbl[i].lv,
          $sformatf("vec%0d", i), tc_s);
      chk($sformatf("vec%0d tbl tc", i), int'(tc_s), int'(tbl[i].tc));
      chk($sformatf("vec%0d tbl count", i), int'(COUNT), tbl[i].cnt);
      chk($sformatf("vec%0d tbl div", i), int'(DIV_OUT), int'(tbl[i].div));
    end

    // Reset mid-count, then resume from zero.
    async_reset("pre-mid");
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 0, "mid up", tc_s);
    chk("mid at 6", int'(COUNT), 6);
    async_reset("mid");
    cyc(1, 1, 0, 0, 0, "mid resume", tc_s);
    chk("mid resume is 1", int'(COUNT), 1);

    // Divider period over 40 enabled up edges from reset.
    async_reset("div");
    toggles = 0;
    for (int i = 1; i <= 40; i++) begin
      prev = DIV_OUT;
      cyc(1, 1, 0, 0, 0, "div run", tc_s);
      if (DIV_OUT != prev) begin
        toggles++;
        chk($sformatf("div toggle at edge %0d", i), i % M, 0);
      end
    end
    chk("div toggle count", toggles, 4);

    // Randomized traffic with occasional async resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(49) == 0) async_reset("rand");
      cyc(($urandom_range(3) != 0), 1'($urandom_range(1)),
          ($urandom_range(15) == 0), ($urandom_range(15) == 0),
          int'($urandom_range(15)), "rand", tc_s);
      n_chk++;
      if (int'(COUNT) < M) n_pass++;
      else $display("FAIL rand range: got %0d, expected < %0d", COUNT, M);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tff_mod_counter.md
Name: tff_mod_counter

Overview:
Synchronous modulo-N up/down counter built from T flip-flop bit cells. It sits directly downstream of the single toggle flop. Each bit is a T cell whose T input is derived from the counter's next-state logic. The block adds enable, direction, synchronous clear/load, a terminal-count strobe and a divided output (DIV_OUT) that toggles on every wrap. Downstream logic uses the counter as a clock-enable/frequency-divider source.

Parameters:
WIDTH, 4, bit width of COUNT and LOAD_VAL
MODULUS, 10, count range 0..MODULUS-1; elaboration error unless 2 <= MODULUS <= 2**WIDTH

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
EN  input  1  count enable
UP  input  1  direction: 1 = up, 0 = down
SCLR  input  1  synchronous clear
LOAD  input  1  synchronous parallel load
LOAD_VAL  input  WIDTH  value to load
COUNT  output  WIDTH  current count (Q of the T cells)
TC  output  1  terminal-count strobe (combinational)
DIV_OUT  output  1  toggles once per wrap
DIV_OUTBAR  output  1  complement of DIV_OUT

Behaviour:
- Reset: RST_N low forces COUNT=0, DIV_OUT=0, DIV_OUTBAR=1 immediately, independent of CLK. Deassertion takes effect from the next rising edge.
- Everything else updates on the rising CLK edge. Priority is SCLR > LOAD > EN > hold.
- SCLR=1: COUNT<=0. DIV_OUT unchanged.
- LOAD=1 (SCLR=0): COUNT<=LOAD_VAL if LOAD_VAL < MODULUS, otherwise COUNT<=MODULUS-1 (clamp). EN is ignored. DIV_OUT unchanged.
- EN=1, UP=1: COUNT<=COUNT+1. At COUNT=MODULUS-1 the count wraps to 0.
- EN=1, UP=0: COUNT<=COUNT-1. At COUNT=0 the count wraps to MODULUS-1.
- EN=0 with no SCLR/LOAD: COUNT holds and every T input is 0.
- Bit-cell implementation:
  - Compute next-state value NXT per the rules above.
  - Drive T[i] = COUNT[i] XOR NXT[i] into each cell.
  - No direct D-path to COUNT is permitted.
- TC is combinational: TC = EN & ~SCLR & ~LOAD & (UP ? COUNT==MODULUS-1 : COUNT==0).
- DIV_OUT is a T cell with T=TC, so it toggles on every edge where a wrap occurs.
  - Up-counting wrap period is 2*MODULUS enabled cycles.
  - DIV_OUTBAR is always ~DIV_OUT.
- Changing UP mid-count takes effect on the next edge, with no extra latency. Example: COUNT=5, UP 1->0 gives next COUNT=4.
- COUNT never leaves 0..MODULUS-1 after reset, including on load and on direction change.
- Latency: one cycle from the control input to COUNT; zero cycles from COUNT/controls to TC.
- Reset asserted mid-count: COUNT and DIV_OUT clear at once. Counting resumes from 0.

Decomposition:
- Package tff_counter_pkg holds:
  - enum op_t {OP_HOLD, OP_CLEAR, OP_LOAD, OP_UP, OP_DOWN}, used for priority decode;
  - a function next_count(cur, op, load_val), parameterised via WIDTH/MODULUS at the call site.
- Sub-module tff_cell (CLK, RST_N, T, Q, QBAR) is the one natural sub-module.
  - Async active-low reset to Q=0; toggles when T=1.
  - Instantiated WIDTH times for COUNT, plus once for DIV_OUT.

Test Plan:
- Reset mid-count: count to 6, pull RST_N low between edges -> COUNT=0, DIV_OUT=0, DIV_OUTBAR=1 before the next edge. Release, EN=1, UP=1 -> COUNT=1 after the first edge.
- Up wrap: from 0 with EN=1, UP=1 for 12 edges -> COUNT 1..9,0,1,2. TC=1 only while COUNT=9. DIV_OUT goes 0->1 on the 9->0 edge.
- Down wrap: LOAD_VAL=3, LOAD=1 for one edge, then UP=0, EN=1 for 5 edges -> COUNT 3,2,1,0,9,8. TC=1 while COUNT=0. DIV_OUT toggles on the 0->9 edge.
- Load clamp and priority:
  - LOAD_VAL=13, LOAD=1, EN=0 -> COUNT=9.
  - SCLR=1 together with LOAD=1, LOAD_VAL=5 -> COUNT=0. DIV_OUT unchanged in both cases.
- Hold and direction change:
  - At COUNT=5, EN=0 for 3 edges -> COUNT stays 5 and TC=0.
  - Then EN=1, UP=0 -> 4.
  - Then UP=1 -> 5.
- Divider period: EN=1, UP=1 for 40 edges from reset -> DIV_OUT toggles exactly 4 times, every 10 edges. DIV_OUTBAR equals ~DIV_OUT throughout.
